param_calculator: RTL
=====================

PARAM_CALCULATOR -- requirements
Module: param_calculator

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; legal range 4..32.
REQ-002 Parameter: CNT_W, $clog2(WIDTH)+1, width of the iteration counter.
REQ-003 Port: Clk  input  1  single clock; all state changes occur on the rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-high reset.
REQ-005 Port: In  input  WIDTH  operand data; sampled in GET_A and GET_B.
REQ-006 Port: SCEN  input  1  single-cycle confirm pulse.
REQ-007 Port: ButU/ButD/ButR/ButL  input  1 each  operation select: MUL, DIV, ADD, SUB.
REQ-008 Port: A, B  output  WIDTH  registered operands.
REQ-009 Port: C  output  2*WIDTH  result; holds the full product for MUL, the quotient for DIV, and the zero-extended result otherwise.
REQ-010 Port: R  output  WIDTH  remainder for DIV; 0 for all other operations.
REQ-011 Port: Flag  output  1  overflow: ADD carry, SUB borrow, or MUL product wider than WIDTH.
REQ-012 Port: Busy  output  1  high while in MUL or DIV.
REQ-013 Port: Done  output  1  high while in DONE.
REQ-014 Port: QI, QGet_A, QGet_B, QGet_Op, QAdd, QSub, QMul, QDiv, QErr, QDone  output  1 each  one-hot state indicators.

Function
REQ-015 The state machine SHALL be one-hot with the states INITIAL, GET_A, GET_B, GET_OP, ADD, SUB, MUL, DIV, ERR, DONE; exactly one Q* output is high at any time.
REQ-016 INITIAL SHALL clear A, B, C, R, Flag and the counter, and SHALL move to GET_A on SCEN.
REQ-017 GET_A SHALL load A<=In every cycle and move to GET_B on SCEN; GET_B SHALL do the same for B and move to GET_OP.
REQ-018 GET_OP SHALL use fixed priority ButU > ButD > ButR > ButL, ignore SCEN, and stay in GET_OP while no button is high.
REQ-019 ButD with B==0 SHALL go to ERR; ButD with B!=0 SHALL go to DIV.
REQ-020 On leaving GET_OP: C<=0, R<=0, counter<=0, Flag<=0, and the working registers SHALL load from A and B.
REQ-021 ADD SHALL last one cycle: C<=A+B (WIDTH+1 bits, zero-extended), Flag<=carry out of bit WIDTH-1; next state DONE.
REQ-022 SUB SHALL last one cycle: C<=(A-B) modulo 2^WIDTH, zero-extended, Flag<=(A<B); next state DONE.
REQ-023 MUL SHALL be an iterative shift-add unsigned multiply lasting exactly WIDTH cycles, examining one multiplier bit per cycle, LSB first; after the final iteration C SHALL equal A*B (2*WIDTH bits), Flag SHALL equal (C[2*WIDTH-1:WIDTH]!=0), and the next state SHALL be DONE.
REQ-024 DIV SHALL be an iterative restoring unsigned divide lasting exactly WIDTH cycles; on exit C SHALL equal the zero-extended A/B, R SHALL equal A%B, and Flag SHALL be 0.
REQ-025 The counter SHALL increment once per MUL or DIV cycle, and the iteration SHALL terminate when counter==WIDTH-1.
REQ-026 Latency from the GET_OP button edge to Done high SHALL be 2 cycles for ADD/SUB and WIDTH+1 cycles for MUL/DIV.
REQ-027 All button and SCEN inputs SHALL be ignored while in ADD, SUB, MUL or DIV.
REQ-028 ERR SHALL clear A, B, C and R, set Flag<=1, and return to INITIAL on SCEN.
REQ-029 DONE SHALL hold A, B, C, R and Flag stable and return to INITIAL on SCEN.
REQ-030 Edge cases: A=0 or B=0 in MUL SHALL still take WIDTH cycles and give C=0 with Flag=0; DIV with A<B SHALL give C=0 and R=A.

Reset
REQ-031 Reset high SHALL immediately force INITIAL with A, B, C, R, Flag, Busy, Done and the counter at 0, independent of Clk.
REQ-032 Reset asserted mid-MUL or mid-DIV SHALL abandon the operation with no partial result visible.
REQ-033 After Reset deasserts, the block SHALL wait in INITIAL for SCEN.

Verification (WIDTH=16 unless noted)
REQ-034 A=0xFFFF, B=0x0001, ButR -> C=0x10000, Flag=1, Done 2 cycles after the button.
REQ-035 A=5, B=9, ButL -> C=0xFFFC, Flag=1.
REQ-036 A=0x0100, B=0x0100, ButU -> Busy for 16 cycles, C=0x10000, Flag=1; then A=300, B=7 -> C=2100, Flag=0.
REQ-037 A=1000, B=7, ButD -> C=142, R=6, Flag=0, Done 17 cycles after the button; B=0 with ButD -> ERR, Flag=1.
REQ-038 ButU and ButL pressed in the same cycle -> MUL taken; Reset pulsed on the 5th MUL cycle -> INITIAL, with all outputs 0.
REQ-039 WIDTH=8: A=255, B=255, ButU -> C=0xFE01, Flag=1, after 8 Busy cycles.

Source files
------------

// File: rtl/param_calculator.sv
// Iterative unsigned calculator: operands are entered with SCEN, then one of
// add/sub (single cycle) or shift-add multiply / restoring divide (WIDTH cycles).
module param_calculator #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     In,
    input  logic                 SCEN,
    input  logic                 ButU,
    input  logic                 ButD,
    input  logic                 ButR,
    input  logic                 ButL,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   C,
    output logic [WIDTH-1:0]     R,
    output logic                 Flag,
    output logic                 Busy,
    output logic                 Done,
    output logic                 QI,
    output logic                 QGet_A,
    output logic                 QGet_B,
    output logic                 QGet_Op,
    output logic                 QAdd,
    output logic                 QSub,
    output logic                 QMul,
    output logic                 QDiv,
    output logic                 QErr,
    output logic                 QDone
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [9:0] {
        S_INIT  = 10'b00_0000_0001,
        S_GET_A = 10'b00_0000_0010,
        S_GET_B = 10'b00_0000_0100,
        S_GET_OP= 10'b00_0000_1000,
        S_ADD   = 10'b00_0001_0000,
        S_SUB   = 10'b00_0010_0000,
        S_MUL   = 10'b00_0100_0000,
        S_DIV   = 10'b00_1000_0000,
        S_ERR   = 10'b01_0000_0000,
        S_DONE  = 10'b10_0000_0000
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [W2-1:0]      mcand;
    logic [WIDTH-1:0]   wq;       // multiplier (MUL) or dividend/quotient (DIV)
    logic [WIDTH-1:0]   divisor;
    logic [W2-1:0]      mul_sum;
    logic [WIDTH:0]     div_res;
    logic [WIDTH:0]     add_sum;
    logic               last_iter;

    // One restoring-divide step: returns {quotient bit, new partial remainder}.
    function automatic logic [WIDTH:0] div_step(input logic [WIDTH-1:0] rem,
                                                 input logic msb,
                                                 input logic [WIDTH-1:0] d);
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        trial = {rem, msb};
        diff  = trial - {1'b0, d};
        if (trial >= {1'b0, d})
            return {1'b1, diff[WIDTH-1:0]};
        else
            return {1'b0, trial[WIDTH-1:0]};
    endfunction

    always_comb begin
        mul_sum   = C + (wq[0] ? mcand : '0);
        div_res   = div_step(R, wq[WIDTH-1], divisor);
        add_sum   = {1'b0, A} + {1'b0, B};
        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_INIT;
            A       <= '0;
            B       <= '0;
            C       <= '0;
            R       <= '0;
            Flag    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            wq      <= '0;
            divisor <= '0;
        end else begin
            unique case (state)
                S_INIT: begin
                    A    <= '0;
                    B    <= '0;
                    C    <= '0;
                    R    <= '0;
                    Flag <= 1'b0;
                    cnt  <= '0;
                    if (SCEN) state <= S_GET_A;
                end
                S_GET_A: begin
                    A <= In;
                    if (SCEN) state <= S_GET_B;
                end
                S_GET_B: begin
                    B <= In;
                    if (SCEN) state <= S_GET_OP;
                end
                S_GET_OP: begin
                    if (ButU | ButD | ButR | ButL) begin
                        C       <= '0;
                        R       <= '0;
                        cnt     <= '0;
                        Flag    <= 1'b0;
                        mcand   <= {{WIDTH{1'b0}}, A};
                        wq      <= ButU ? B : A;
                        divisor <= B;
                        if (ButU)          state <= S_MUL;
                        else if (ButD)     state <= (B == '0) ? S_ERR : S_DIV;
                        else if (ButR)     state <= S_ADD;
                        else               state <= S_SUB;
                    end
                end
                S_ADD: begin
                    C     <= {{(WIDTH-1){1'b0}}, add_sum};
                    Flag  <= add_sum[WIDTH];
                    state <= S_DONE;
                end
                S_SUB: begin
                    C     <= {{WIDTH{1'b0}}, A - B};
                    Flag  <= (A < B);
                    state <= S_DONE;
                end
                S_MUL: begin
                    C     <= mul_sum;
                    mcand <= mcand << 1;
                    wq    <= wq >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        Flag  <= |mul_sum[W2-1:WIDTH];
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    R   <= div_res[WIDTH-1:0];
                    wq  <= {wq[WIDTH-2:0], div_res[WIDTH]};
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        C     <= {{WIDTH{1'b0}}, wq[WIDTH-2:0], div_res[WIDTH]};
                        Flag  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_ERR: begin
                    A    <= '0;
                    B    <= '0;
                    C    <= '0;
                    R    <= '0;
                    Flag <= 1'b1;
                    if (SCEN) state <= S_INIT;
                end
                S_DONE: begin
                    if (SCEN) state <= S_INIT;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign QI      = (state == S_INIT);
    assign QGet_A  = (state == S_GET_A);
    assign QGet_B  = (state == S_GET_B);
    assign QGet_Op = (state == S_GET_OP);
    assign QAdd    = (state == S_ADD);
    assign QSub    = (state == S_SUB);
    assign QMul    = (state == S_MUL);
    assign QDiv    = (state == S_DIV);
    assign QErr    = (state == S_ERR);
    assign QDone   = (state == S_DONE);
    assign Busy    = QMul | QDiv;
    assign Done    = QDone;

endmodule
